// File: rtl/gamepad_pkg.sv
// Definitions shared by the device-side gamepad emulator and the host-side scanner.
package gamepad_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } gp_state_e;

    // Wire polarity: a pressed button (1) drives the data line low.
    localparam logic WIRE_INVERT = 1'b1;

    localparam int unsigned DEF_REG_WIDTH  = 12;
    localparam int unsigned DEF_DATA_WIDTH = 2;

endpackage

// File: rtl/gamepad_pin_sync.sv
// Multi-stage synchronizer for one asynchronous pad pin, followed by rise/fall edge detection.
module gamepad_pin_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        level = sync_q[SYNC_STAGES-1];
        rise  = level & ~dly_q;
        fall  = ~level & dly_q;
    end

endmodule

// File: rtl/gamepad_dev.sv
// Device end of an NES/SNES-style serial pad link: latches `value` on the console latch and
// shifts it out LSB first on each console clock rise, one shift register per data line.
module gamepad_dev
    import gamepad_pkg::*;
#(
    parameter int unsigned REG_WIDTH   = DEF_REG_WIDTH,
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          FILL_LEVEL  = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             gp_latch,
    input  logic                             gp_clk,
    output logic [DATA_WIDTH-1:0]            gp_data,
    input  logic [REG_WIDTH*DATA_WIDTH-1:0]  value,
    output logic                             evt_poll,
    output logic                             evt_done,
    output logic                             busy
);

    localparam int unsigned CNT_W = $clog2(REG_WIDTH) + 1;

    logic l_s, l_rise, l_fall;
    logic c_s, c_rise, c_fall;

    gamepad_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_latch_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (gp_latch),
        .level(l_s),
        .rise (l_rise),
        .fall (l_fall)
    );

    gamepad_pin_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_clk_sync (
        .clk  (clk),
        .rst  (rst),
        .pin  (gp_clk),
        .level(c_s),
        .rise (c_rise),
        .fall (c_fall)
    );

    // Only rise strobes and the latch fall drive the protocol; levels are kept for visibility.
    logic unused_pins;
    assign unused_pins = ^{l_s, c_s, c_fall};

    gp_state_e                            state_q, state_d;
    logic [CNT_W-1:0]                     bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0][REG_WIDTH-1:0] sr_q, sr_d;
    logic [DATA_WIDTH-1:0][REG_WIDTH-1:0] sr_load, sr_shift;
    logic                                 evt_poll_d, evt_done_d;
    logic                                 evt_poll_q, evt_done_q;
    logic [CNT_W-1:0]                     bit_cnt_inc;

    always_comb begin
        for (int k = 0; k < DATA_WIDTH; k++) begin
            sr_load[k]  = value[k*REG_WIDTH +: REG_WIDTH];
            sr_shift[k] = {FILL_LEVEL, sr_q[k][REG_WIDTH-1:1]};
        end
    end

    assign bit_cnt_inc = bit_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        evt_poll_d = 1'b0;
        evt_done_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Latch rise reloads at once so bit 0 appears with the minimum latency.
                if (l_rise) begin
                    state_d = ST_LOAD;
                    sr_d    = sr_load;
                end else if (c_rise) begin
                    sr_d = sr_shift;
                end
            end
            ST_LOAD: begin
                sr_d = sr_load;
                if (l_fall) begin
                    state_d    = ST_SHIFT;
                    bit_cnt_d  = '0;
                    evt_poll_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (l_rise) begin
                    state_d = ST_LOAD;
                    sr_d    = sr_load;
                end else if (c_rise) begin
                    sr_d      = sr_shift;
                    bit_cnt_d = bit_cnt_inc;
                    if (bit_cnt_inc == CNT_W'(REG_WIDTH)) begin
                        evt_done_d = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            sr_q       <= '0;
            evt_poll_q <= 1'b0;
            evt_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
            evt_poll_q <= evt_poll_d;
            evt_done_q <= evt_done_d;
        end
    end

    always_comb begin
        for (int k = 0; k < DATA_WIDTH; k++) begin
            gp_data[k] = sr_q[k][0] ^ WIRE_INVERT;
        end
    end

    assign evt_poll = evt_poll_q;
    assign evt_done = evt_done_q;
    assign busy     = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_gamepad_dev.sv
// Directed self-checking bench for gamepad_dev with default parameters (12 bits x 2 lines).
module tb_gamepad_dev;

    localparam int unsigned RW = 12;
    localparam int unsigned DW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            gp_latch = 1'b0;
    logic            gp_clk = 1'b0;
    logic [DW-1:0]   gp_data;
    logic [RW*DW-1:0] value = '0;
    logic            evt_poll, evt_done, busy;

    int compared   = 0;
    int mismatched = 0;
    int n_poll     = 0;
    int n_done     = 0;

    gamepad_dev dut (
        .clk     (clk),
        .rst     (rst),
        .gp_latch(gp_latch),
        .gp_clk  (gp_clk),
        .gp_data (gp_data),
        .value   (value),
        .evt_poll(evt_poll),
        .evt_done(evt_done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (evt_poll) n_poll <= n_poll + 1;
        if (evt_done) n_done <= n_done + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected wire pair for bit i of an image: active-low, line 1 field starts at RW.
    function automatic logic [1:0] wire_bits(input logic [RW*DW-1:0] v, input int i);
        logic [1:0] r;
        r[0] = ~v[i];
        r[1] = ~v[RW + i];
        return r;
    endfunction

    task automatic latch_pulse();
        gp_latch = 1'b1;
        cyc(8);
        gp_latch = 1'b0;
        cyc(10);
    endtask

    task automatic clk_pulse();
        gp_clk = 1'b1;
        cyc(10);
        gp_clk = 1'b0;
        cyc(10);
    endtask

    logic [RW*DW-1:0] img;

    initial begin
        // Reset with pins toggling.
        for (int i = 0; i < 6; i++) begin
            gp_latch = i[0];
            gp_clk   = ~i[0];
            cyc(1);
        end
        check("rst_data", 32'(gp_data), 32'h3);
        check("rst_busy", 32'(busy), 32'h0);
        gp_latch = 1'b0;
        gp_clk   = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(10);
        check("idle_data", 32'(gp_data), 32'h3);
        check("idle_busy", 32'(busy), 32'h0);
        check("idle_events", 32'(n_poll + n_done), 32'h0);

        // Basic poll.
        value = 24'h0A55A3;
        img   = value;
        latch_pulse();
        check("poll_busy", 32'(busy), 32'h1);
        check("poll_cnt", 32'(n_poll), 32'd1);
        for (int i = 0; i < RW; i++) begin
            check($sformatf("basic_bit%0d", i), 32'(gp_data), 32'(wire_bits(img, i)));
            clk_pulse();
        end
        check("basic_done", 32'(n_done), 32'd1);
        check("basic_idle", 32'(busy), 32'h0);

        // Overclock: fill level shifts in, no further done.
        for (int i = 0; i < 4; i++) begin
            check($sformatf("over_bit%0d", RW + i), 32'(gp_data), 32'h0);
            clk_pulse();
        end
        check("over_done", 32'(n_done), 32'd1);
        check("over_cnt", 32'(dut.bit_cnt_q), 32'd12);

        // Abort: relatch after 5 clocks.
        value = 24'hFFF_000;
        latch_pulse();
        for (int i = 0; i < 5; i++) clk_pulse();
        value = 24'h001_001;
        img   = value;
        gp_latch = 1'b1;
        cyc(6);
        check("abort_reload", 32'(gp_data), 32'(wire_bits(img, 0)));
        check("abort_busy", 32'(busy), 32'h0);
        check("abort_no_done", 32'(n_done), 32'd1);
        gp_latch = 1'b0;
        cyc(10);
        check("abort_poll", 32'(n_poll), 32'd3);
        for (int i = 0; i < RW; i++) clk_pulse();
        check("abort_redo_done", 32'(n_done), 32'd2);

        // Latch fall and clock rise together: clock ignored. Value changed mid-shift.
        value = 24'h9C3_36C;
        img   = value;
        gp_latch = 1'b1;
        cyc(8);
        gp_latch = 1'b0;
        gp_clk   = 1'b1;
        cyc(10);
        gp_clk   = 1'b0;
        cyc(10);
        check("race_bit0", 32'(gp_data), 32'(wire_bits(img, 0)));
        for (int i = 1; i < RW; i++) begin
            clk_pulse();
            if (i == 3) value = ~value;
            check($sformatf("race_bit%0d", i), 32'(gp_data), 32'(wire_bits(img, i)));
        end
        clk_pulse();
        check("race_done", 32'(n_done), 32'd3);
        check("race_poll", 32'(n_poll), 32'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
